// File: rtl/mesh_seq_ctrl.sv
// Sequencer for the systolic MAC mesh: one matrix-vector pass per start command.
// Optional vbram-to-vbram copy command is enabled by defining MESH_SEQ_CTRL_COPY_EN.
module mesh_seq_ctrl #(
   parameter int IDX_WIDTH_FOR_NODES = 6,
   parameter int NUM_NODES           = 2**IDX_WIDTH_FOR_NODES,
   parameter int ADDR_WIDTH          = 10,
   parameter int MAC_LAT             = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [ADDR_WIDTH-1:0]          vec_len,
   input  logic                           src_sel,
   input  logic                           dst_sel,
   input  logic [ADDR_WIDTH-1:0]          dst_base,
   input  logic                           use_init,
`ifdef MESH_SEQ_CTRL_COPY_EN
   input  logic                           copy,
`endif
   output logic                           busy,
   output logic                           done,
   output logic                           mbram_en,
   output logic [ADDR_WIDTH-1:0]          mbram_addr,
   output logic [ADDR_WIDTH-1:0]          vbram0_addr,
   output logic                           vbram0_we,
   output logic [ADDR_WIDTH-1:0]          vbram1_addr,
   output logic                           vbram1_we,
   output logic [NUM_NODES-1:0]           sclrs,
   output logic [1:0]                     asel,
   output logic [NUM_NODES-1:0]           csels,
   output logic [IDX_WIDTH_FOR_NODES-1:0] ressel,
   output logic [1:0]                     dinsel
);

   localparam int DRAIN_W = $clog2(NUM_NODES + MAC_LAT + 1);
   localparam int CNT_W   = (ADDR_WIDTH > DRAIN_W) ? ADDR_WIDTH : DRAIN_W;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(NUM_NODES + MAC_LAT);
   localparam logic [CNT_W-1:0] WB_LAST    = CNT_W'(NUM_NODES - 1);

   typedef enum logic [2:0] {
      IDLE, STREAM, DRAIN, WB, DONE
`ifdef MESH_SEQ_CTRL_COPY_EN
      , COPY
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    load_cmd;
   logic [ADDR_WIDTH-1:0]   len_q, base_q;
   logic                    src_q, dst_q, init_q;
   logic [CNT_W-1:0]        len_last;
   logic                    first_q, first_d;

   // Outputs are registered from the current state, so they trail the state by one cycle.
   logic                           busy_d, done_d, mbram_en_d;
   logic [ADDR_WIDTH-1:0]          mbram_addr_d;
   logic [ADDR_WIDTH-1:0]          vb_addr_q [2];
   logic [ADDR_WIDTH-1:0]          vb_addr_d [2];
   logic [1:0]                     vb_we_q, vb_we_d;
   logic [NUM_NODES-1:0]           sclrs_d, csels_d;
   logic [1:0]                     asel_d;
   logic [IDX_WIDTH_FOR_NODES-1:0] ressel_d;

`ifdef MESH_SEQ_CTRL_COPY_EN
   logic                  cp_q, cp_d;
   logic [ADDR_WIDTH-1:0] cp_cnt_q, cp_cnt_d;
   logic [1:0]            dinsel_q, dinsel_d;
`endif

   assign len_last = CNT_W'(len_q) - CNT_W'(1);

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_cmd = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               if (vec_len == '0) begin
                  state_d = DONE;
`ifdef MESH_SEQ_CTRL_COPY_EN
               end else if (copy && (src_sel == dst_sel)) begin
                  state_d = DONE;
               end else if (copy) begin
                  state_d  = COPY;
                  load_cmd = 1'b1;
`endif
               end else begin
                  state_d  = STREAM;
                  load_cmd = 1'b1;
               end
            end
         end
         STREAM: begin
            if (cnt_q == len_last) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d = WB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WB: begin
            if (cnt_q == WB_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef MESH_SEQ_CTRL_COPY_EN
         COPY: begin
            if (cnt_q == len_last) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      // A zero-length or degenerate command never raises busy.
      busy_d       = (state_d != IDLE) && !(state_q == IDLE && state_d == DONE);
      done_d       = (state_q == DONE);
      mbram_en_d   = 1'b0;
      mbram_addr_d = '0;
      vb_addr_d[0] = '0;
      vb_addr_d[1] = '0;
      vb_we_d      = 2'b00;
      sclrs_d      = (state_q == IDLE || state_q == DONE) ? '1 : '0;
      asel_d       = 2'b00;
      ressel_d     = '0;
      first_d      = (state_q == STREAM) && (cnt_q == '0);
      csels_d      = csels << 1;
      csels_d[0]   = ~first_q;

      if (state_q == STREAM) begin
         mbram_en_d          = 1'b1;
         mbram_addr_d        = ADDR_WIDTH'(cnt_q);
         vb_addr_d[src_q]    = ADDR_WIDTH'(cnt_q);
         asel_d              = {init_q, src_q};
      end
      if (state_q == WB) begin
         ressel_d            = IDX_WIDTH_FOR_NODES'(cnt_q);
         vb_addr_d[dst_q]    = base_q + ADDR_WIDTH'(cnt_q);
         vb_we_d[dst_q]      = 1'b1;
      end
`ifdef MESH_SEQ_CTRL_COPY_EN
      cp_d     = (state_q == COPY);
      cp_cnt_d = ADDR_WIDTH'(cnt_q);
      dinsel_d = 2'b00;
      if (state_q == COPY) vb_addr_d[src_q] = ADDR_WIDTH'(cnt_q);
      // Write side lags the read by the one-cycle BRAM latency.
      if (cp_q) begin
         vb_addr_d[dst_q] = base_q + cp_cnt_q;
         vb_we_d[dst_q]   = 1'b1;
         dinsel_d[dst_q]  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         len_q        <= '0;
         base_q       <= '0;
         src_q        <= 1'b0;
         dst_q        <= 1'b0;
         init_q       <= 1'b0;
         first_q      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         mbram_en     <= 1'b0;
         mbram_addr   <= '0;
         vb_addr_q[0] <= '0;
         vb_addr_q[1] <= '0;
         vb_we_q      <= 2'b00;
         sclrs        <= '1;
         asel         <= 2'b00;
         csels        <= '1;
         ressel       <= '0;
`ifdef MESH_SEQ_CTRL_COPY_EN
         cp_q         <= 1'b0;
         cp_cnt_q     <= '0;
         dinsel_q     <= 2'b00;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         if (load_cmd) begin
            len_q  <= vec_len;
            base_q <= dst_base;
            src_q  <= src_sel;
            dst_q  <= dst_sel;
            init_q <= use_init;
         end
         first_q      <= first_d;
         busy         <= busy_d;
         done         <= done_d;
         mbram_en     <= mbram_en_d;
         mbram_addr   <= mbram_addr_d;
         vb_addr_q[0] <= vb_addr_d[0];
         vb_addr_q[1] <= vb_addr_d[1];
         vb_we_q      <= vb_we_d;
         sclrs        <= sclrs_d;
         asel         <= asel_d;
         csels        <= csels_d;
         ressel       <= ressel_d;
`ifdef MESH_SEQ_CTRL_COPY_EN
         cp_q         <= cp_d;
         cp_cnt_q     <= cp_cnt_d;
         dinsel_q     <= dinsel_d;
`endif
      end
   end

   assign vbram0_addr = vb_addr_q[0];
   assign vbram1_addr = vb_addr_q[1];
   assign vbram0_we   = vb_we_q[0];
   assign vbram1_we   = vb_we_q[1];
`ifdef MESH_SEQ_CTRL_COPY_EN
   assign dinsel      = dinsel_q;
`else
   assign dinsel      = 2'b00;
`endif

endmodule

// File: tb/tb_mesh_seq_ctrl.sv
// Directed self-checking bench for mesh_seq_ctrl (4 nodes, MAC_LAT 2).
// Cycle c means the outputs seen after the c-th rising edge following the start edge.
module tb_mesh_seq_ctrl;

   localparam int IDXW = 2;
   localparam int NN   = 4;
   localparam int AW   = 10;
   localparam int MACL = 2;
   localparam int MAXC = 40;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [AW-1:0]   vec_len;
   logic            src_sel, dst_sel, use_init;
   logic [AW-1:0]   dst_base;
`ifdef MESH_SEQ_CTRL_COPY_EN
   logic            copy;
`endif
   logic            busy, done, mbram_en, vbram0_we, vbram1_we;
   logic [AW-1:0]   mbram_addr, vbram0_addr, vbram1_addr;
   logic [NN-1:0]   sclrs, csels;
   logic [1:0]      asel, dinsel;
   logic [IDXW-1:0] ressel;

   int n_checks = 0;
   int n_fail   = 0;

   logic            t_busy [MAXC], t_done [MAXC], t_mben [MAXC], t_w0 [MAXC], t_w1 [MAXC];
   logic [AW-1:0]   t_mba [MAXC], t_a0 [MAXC], t_a1 [MAXC];
   logic [NN-1:0]   t_sclr [MAXC], t_csel [MAXC];
   logic [1:0]      t_asel [MAXC], t_din [MAXC];
   logic [IDXW-1:0] t_res [MAXC];

   mesh_seq_ctrl #(
      .IDX_WIDTH_FOR_NODES(IDXW), .NUM_NODES(NN), .ADDR_WIDTH(AW), .MAC_LAT(MACL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .src_sel(src_sel),
      .dst_sel(dst_sel), .dst_base(dst_base), .use_init(use_init),
`ifdef MESH_SEQ_CTRL_COPY_EN
      .copy(copy),
`endif
      .busy(busy), .done(done), .mbram_en(mbram_en), .mbram_addr(mbram_addr),
      .vbram0_addr(vbram0_addr), .vbram0_we(vbram0_we), .vbram1_addr(vbram1_addr),
      .vbram1_we(vbram1_we), .sclrs(sclrs), .asel(asel), .csels(csels),
      .ressel(ressel), .dinsel(dinsel)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic launch(input int len, input bit src, input bit dst, input int base,
                         input bit init, input bit cp);
      @(negedge clk);
      vec_len  = AW'(len);
      src_sel  = src;
      dst_sel  = dst;
      dst_base = AW'(base);
      use_init = init;
`ifdef MESH_SEQ_CTRL_COPY_EN
      copy     = cp;
`else
      if (cp) $display("copy requested without copy support");
`endif
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic capture(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         t_busy[c] = busy;    t_done[c] = done;    t_mben[c] = mbram_en;
         t_mba[c]  = mbram_addr;
         t_a0[c]   = vbram0_addr; t_w0[c] = vbram0_we;
         t_a1[c]   = vbram1_addr; t_w1[c] = vbram1_we;
         t_sclr[c] = sclrs;   t_csel[c] = csels;   t_asel[c] = asel;
         t_res[c]  = ressel;  t_din[c]  = dinsel;
      end
   endtask

   // Expected trace of a normal pass: stream in cycles 1..L, write-back starts
   // L+NN+MACL+2, done at L+2*NN+MACL+2.
   task automatic verify_pass(input string nm, input int len, input bit src, input bit dst,
                              input int base, input bit init);
      int wb0, dn;
      logic [AW-1:0] ea [2];
      logic [1:0]    ew;
      logic [NN-1:0] ecs;
      bit in_s, in_wb;
      wb0 = len + NN + MACL + 2;
      dn  = wb0 + NN;
      for (int c = 0; c <= dn + 1; c++) begin
         in_s  = (c >= 1) && (c <= len);
         in_wb = (c >= wb0) && (c < dn);
         ea[0] = '0; ea[1] = '0; ew = 2'b00;
         if (in_s) ea[src] = AW'(c - 1);
         if (in_wb) begin
            ea[dst] = AW'(base) + AW'(c - wb0);
            ew[dst] = 1'b1;
         end
         ecs = '1;
         if (c >= 2 && c < 2 + NN) ecs[c-2] = 1'b0;
         check($sformatf("%s busy c%0d", nm, c), 32'(t_busy[c]), 32'(c < dn));
         check($sformatf("%s done c%0d", nm, c), 32'(t_done[c]), 32'(c == dn));
         check($sformatf("%s mben c%0d", nm, c), 32'(t_mben[c]), 32'(in_s));
         check($sformatf("%s mba c%0d", nm, c), 32'(t_mba[c]), in_s ? 32'(c - 1) : 32'd0);
         check($sformatf("%s a0 c%0d", nm, c), 32'(t_a0[c]), 32'(ea[0]));
         check($sformatf("%s a1 c%0d", nm, c), 32'(t_a1[c]), 32'(ea[1]));
         check($sformatf("%s we0 c%0d", nm, c), 32'(t_w0[c]), 32'(ew[0]));
         check($sformatf("%s we1 c%0d", nm, c), 32'(t_w1[c]), 32'(ew[1]));
         check($sformatf("%s ressel c%0d", nm, c), 32'(t_res[c]), in_wb ? 32'(c - wb0) : 32'd0);
         check($sformatf("%s asel c%0d", nm, c), 32'(t_asel[c]), in_s ? 32'({init, src}) : 32'd0);
         check($sformatf("%s sclrs c%0d", nm, c), 32'(t_sclr[c]),
               (c >= 1 && c < dn) ? 32'd0 : 32'hF);
         check($sformatf("%s csels c%0d", nm, c), 32'(t_csel[c]), 32'(ecs));
         check($sformatf("%s dinsel c%0d", nm, c), 32'(t_din[c]), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; vec_len = '0; src_sel = 1'b0; dst_sel = 1'b0;
      dst_base = '0; use_init = 1'b0;
`ifdef MESH_SEQ_CTRL_COPY_EN
      copy = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst mben", 32'(mbram_en), 32'd0);
      check("rst we", 32'({vbram0_we, vbram1_we}), 32'd0);
      check("rst addr", 32'(mbram_addr | vbram0_addr | vbram1_addr), 32'd0);
      check("rst sclrs", 32'(sclrs), 32'hF);
      check("rst csels", 32'(csels), 32'hF);
      check("rst sel", 32'({asel, ressel, dinsel}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic pass L=3, vbram0 -> vbram1 at base 8, init select on.
      launch(3, 1'b0, 1'b1, 8, 1'b1, 1'b0);
      capture(17);
      verify_pass("p1", 3, 1'b0, 1'b1, 8, 1'b1);

      // Destination address wraps at the top of the vbram.
      launch(2, 1'b1, 1'b0, 1022, 1'b0, 1'b0);
      capture(16);
      verify_pass("wrap", 2, 1'b1, 1'b0, 1022, 1'b0);
      check("wrap addr 3rd write", 32'(t_a0[12]), 32'd0);

      // Same vbram as source and destination.
      launch(1, 1'b1, 1'b1, 5, 1'b0, 1'b0);
      capture(15);
      verify_pass("same", 1, 1'b1, 1'b1, 5, 1'b0);

      // Zero-length command completes in one cycle with no activity.
      launch(0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
      capture(4);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("zero done c%0d", c), 32'(t_done[c]), 32'(c == 1));
         check($sformatf("zero act c%0d", c),
               32'({t_busy[c], t_mben[c], t_w0[c], t_w1[c]}), 32'd0);
      end

      // Reset during the second write-back cycle aborts the pass.
      launch(3, 1'b0, 1'b1, 8, 1'b0, 1'b0);
      capture(13);
      check("abort pre we1", 32'(t_w1[12]), 32'd1);
      check("abort pre ressel", 32'(t_res[12]), 32'd1);
      rst = 1'b1;
      #1;
      check("abort we1", 32'(vbram1_we), 32'd0);
      check("abort sclrs", 32'(sclrs), 32'hF);
      check("abort busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      capture(20);
      for (int c = 0; c < 20; c++)
         check($sformatf("abort no done c%0d", c), 32'({t_done[c], t_w1[c]}), 32'd0);

      // A start after the abort runs normally.
      launch(3, 1'b0, 1'b1, 8, 1'b0, 1'b0);
      capture(17);
      verify_pass("post", 3, 1'b0, 1'b1, 8, 1'b0);

`ifdef MESH_SEQ_CTRL_COPY_EN
      // Copy vbram1 -> vbram0: reads cycles 1..4, writes cycles 2..5, done at 5.
      launch(4, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      capture(8);
      for (int c = 0; c < 8; c++) begin
         check($sformatf("copy a1 c%0d", c), 32'(t_a1[c]),
               (c >= 1 && c <= 4) ? 32'(c - 1) : 32'd0);
         check($sformatf("copy we0 c%0d", c), 32'(t_w0[c]), 32'(c >= 2 && c <= 5));
         check($sformatf("copy a0 c%0d", c), 32'(t_a0[c]),
               (c >= 2 && c <= 5) ? 32'(c - 2) : 32'd0);
         check($sformatf("copy dinsel c%0d", c), 32'(t_din[c]),
               (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
         check($sformatf("copy done c%0d", c), 32'(t_done[c]), 32'(c == 5));
         check($sformatf("copy quiet c%0d", c), 32'({t_mben[c], t_w1[c]}), 32'd0);
      end
      // Copy onto the same vbram finishes at once with no writes.
      launch(4, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      capture(4);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("selfcopy done c%0d", c), 32'(t_done[c]), 32'(c == 1));
         check($sformatf("selfcopy we c%0d", c), 32'({t_w0[c], t_w1[c]}), 32'd0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
